// File: rtl/reg_host_seq.sv
// Host-side register initiator: single read/write commands plus an autonomous
// run sequence that enables the logic and polls status bit0 until halt or timeout.
module reg_host_seq #(
  parameter int unsigned  POLL_INTERVAL = 16,
  parameter logic [31:0]  TIMEOUT       = 32'h000F_FFFF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cmd_valid,
  input  logic        i_cmd_write,
  input  logic [31:0] i_cmd_addr,
  input  logic [31:0] i_cmd_data,
  output logic        o_cmd_ready,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_data,
  input  logic        i_start,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_timeout,
  output logic [31:0] o_cycles,
  output logic [1:0]  o_reg_ctl,
  output logic [31:0] o_reg_addr,
  output logic [31:0] o_reg_data,
  input  logic [31:0] i_reg_data,
  output logic        o_logic_en
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD_ISSUE,
    S_CMD_WAIT,
    S_CMD_RSP,
    S_RUN,
    S_POLL_ISSUE,
    S_POLL_WAIT
  } state_t;

  localparam logic [1:0]  CTL_NOP   = 2'd0;
  localparam logic [1:0]  CTL_READ  = 2'd1;
  localparam logic [1:0]  CTL_WRITE = 2'd2;
  localparam logic [31:0] POLL_LAST = 32'(POLL_INTERVAL - 1);

  state_t      state_q, state_d;
  logic        cmd_write_q, cmd_write_d;
  logic [1:0]  reg_ctl_q, reg_ctl_d;
  logic [31:0] reg_addr_q, reg_addr_d;
  logic [31:0] reg_data_q, reg_data_d;
  logic        logic_en_q, logic_en_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        done_q, done_d;
  logic        timeout_q, timeout_d;
  logic [31:0] cycles_q, cycles_d;
  logic [31:0] poll_cnt_q, poll_cnt_d;
  logic [31:0] cycles_inc;
  logic        in_run;
  logic        run_expire;

  always_comb begin
    state_d     = state_q;
    cmd_write_d = cmd_write_q;
    reg_ctl_d   = CTL_NOP;
    reg_addr_d  = reg_addr_q;
    reg_data_d  = reg_data_q;
    logic_en_d  = logic_en_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    done_d      = done_q;
    timeout_d   = timeout_q;
    cycles_d    = cycles_q;
    poll_cnt_d  = poll_cnt_q;

    cycles_inc = (cycles_q == TIMEOUT) ? cycles_q : cycles_q + 32'd1;
    if (logic_en_q) begin
      cycles_d = cycles_inc;
    end
    in_run     = (state_q == S_RUN) || (state_q == S_POLL_ISSUE) || (state_q == S_POLL_WAIT);
    run_expire = in_run && logic_en_q && (cycles_inc == TIMEOUT);

    case (state_q)
      S_IDLE: begin
        if (i_cmd_valid) begin
          cmd_write_d = i_cmd_write;
          reg_addr_d  = i_cmd_addr;
          reg_data_d  = i_cmd_data;
          reg_ctl_d   = i_cmd_write ? CTL_WRITE : CTL_READ;
          state_d     = S_CMD_ISSUE;
        end else if (i_start) begin
          done_d     = 1'b0;
          timeout_d  = 1'b0;
          cycles_d   = 32'd0;
          logic_en_d = 1'b1;
          poll_cnt_d = 32'd0;
          state_d    = S_RUN;
        end
      end
      S_CMD_ISSUE: begin
        if (cmd_write_q) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = 32'd0;
          state_d     = S_CMD_RSP;
        end else begin
          state_d = S_CMD_WAIT;
        end
      end
      S_CMD_WAIT: begin
        rsp_data_d  = i_reg_data;
        rsp_valid_d = 1'b1;
        state_d     = S_CMD_RSP;
      end
      S_CMD_RSP: begin
        state_d = S_IDLE;
      end
      S_RUN: begin
        if (poll_cnt_q == POLL_LAST) begin
          reg_ctl_d  = CTL_READ;
          reg_addr_d = 32'd0;
          state_d    = S_POLL_ISSUE;
        end else begin
          poll_cnt_d = poll_cnt_q + 32'd1;
        end
      end
      S_POLL_ISSUE: begin
        state_d = S_POLL_WAIT;
      end
      S_POLL_WAIT: begin
        if (i_reg_data[0]) begin
          logic_en_d = 1'b0;
          done_d     = 1'b1;
          state_d    = S_IDLE;
        end else begin
          poll_cnt_d = 32'd0;
          state_d    = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Timeout overrides a halt seen on the same edge and cancels any pending poll read.
    if (run_expire) begin
      logic_en_d = 1'b0;
      timeout_d  = 1'b1;
      done_d     = 1'b0;
      reg_ctl_d  = CTL_NOP;
      state_d    = S_IDLE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      cmd_write_q <= 1'b0;
      reg_ctl_q   <= CTL_NOP;
      reg_addr_q  <= 32'd0;
      reg_data_q  <= 32'd0;
      logic_en_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      cycles_q    <= 32'd0;
      poll_cnt_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      cmd_write_q <= cmd_write_d;
      reg_ctl_q   <= reg_ctl_d;
      reg_addr_q  <= reg_addr_d;
      reg_data_q  <= reg_data_d;
      logic_en_q  <= logic_en_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      cycles_q    <= cycles_d;
      poll_cnt_q  <= poll_cnt_d;
    end
  end

  assign o_cmd_ready = (state_q == S_IDLE) && !i_rst;
  assign o_busy      = (state_q != S_IDLE);
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_done      = done_q;
  assign o_timeout   = timeout_q;
  assign o_cycles    = cycles_q;
  assign o_reg_ctl   = reg_ctl_q;
  assign o_reg_addr  = reg_addr_q;
  assign o_reg_data  = reg_data_q;
  assign o_logic_en  = logic_en_q;

endmodule

// File: tb/tb_reg_host_seq.sv
// Bench for reg_host_seq: a behavioural top-level register model answers the
// reads, and command/run outcomes are compared against bench-computed results.
module tb_reg_host_seq;

  localparam int P  = 16;
  localparam int T  = 100;
  localparam int PER = P + 2;

  logic        i_clk;
  logic        i_rst;
  logic        i_cmd_valid;
  logic        i_cmd_write;
  logic [31:0] i_cmd_addr;
  logic [31:0] i_cmd_data;
  logic        o_cmd_ready;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_data;
  logic        i_start;
  logic        o_busy;
  logic        o_done;
  logic        o_timeout;
  logic [31:0] o_cycles;
  logic [1:0]  o_reg_ctl;
  logic [31:0] o_reg_addr;
  logic [31:0] o_reg_data;
  logic [31:0] i_reg_data;
  logic        o_logic_en;

  reg_host_seq #(.POLL_INTERVAL(P), .TIMEOUT(32'(T))) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_cmd_valid(i_cmd_valid), .i_cmd_write(i_cmd_write),
    .i_cmd_addr(i_cmd_addr), .i_cmd_data(i_cmd_data),
    .o_cmd_ready(o_cmd_ready), .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data),
    .i_start(i_start), .o_busy(o_busy), .o_done(o_done), .o_timeout(o_timeout),
    .o_cycles(o_cycles), .o_reg_ctl(o_reg_ctl), .o_reg_addr(o_reg_addr),
    .o_reg_data(o_reg_data), .i_reg_data(i_reg_data), .o_logic_en(o_logic_en)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;

  // Top-level register model: status at address 0, plain storage elsewhere.
  logic [31:0] mem [16];
  logic [31:0] exp_mem [16];
  int          en_count = 0;
  int          halt_after = 1000000;
  logic [1:0]  tm_ctl;
  logic [31:0] tm_addr, tm_data;
  bit          tm_halted;

  bit          exp_done = 0;
  bit          exp_to = 0;
  int          exp_cyc = 0;

  initial begin
    i_reg_data = 32'd0;
    for (int k = 0; k < 16; k++) mem[k] = 32'd0;
    forever begin
      @(negedge i_clk);
      if (o_logic_en) en_count++;
      tm_ctl    = o_reg_ctl;
      tm_addr   = o_reg_addr;
      tm_data   = o_reg_data;
      tm_halted = (en_count >= halt_after);
      @(posedge i_clk);
      #1;
      if (tm_ctl == 2'd1) begin
        i_reg_data = (tm_addr == 32'd0) ? {31'd0, tm_halted} : mem[tm_addr[3:0]];
      end else if (tm_ctl == 2'd2 && tm_addr != 32'd0) begin
        mem[tm_addr[3:0]] = tm_data;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    end
  endtask

  // Outcome of a run from the halt point H: polls issue at enabled cycle k*PER-1
  // and take effect at k*PER; the run is cut at exactly T enabled cycles.
  function automatic void run_model(input int h, output int cyc, output bit done,
                                    output bit to, output int polls);
    done = 0; to = 1; cyc = T; polls = 0;
    for (int k = 1; k * PER - 1 <= T; k++) begin
      polls = k;
      if (k * PER - 1 >= h && k * PER < T) begin
        done = 1; to = 0; cyc = k * PER;
        return;
      end
    end
  endfunction

  task automatic check_reset(input bit ready_exp);
    chk("rst_reg_ctl", 32'(o_reg_ctl), 0);
    chk("rst_reg_addr", o_reg_addr, 0);
    chk("rst_reg_data", o_reg_data, 0);
    chk("rst_logic_en", 32'(o_logic_en), 0);
    chk("rst_rsp_valid", 32'(o_rsp_valid), 0);
    chk("rst_rsp_data", o_rsp_data, 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_done", 32'(o_done), 0);
    chk("rst_timeout", 32'(o_timeout), 0);
    chk("rst_cycles", o_cycles, 0);
    chk("rst_cmd_ready", 32'(o_cmd_ready), 32'(ready_exp));
  endtask

  task automatic do_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input bit with_start, input logic [31:0] exp_rsp, input int exp_lat);
    int lat = 0;
    int nctl = 0;
    int en_seen = 0;
    bit got = 0;
    logic [1:0]  ctl_seen = 2'd0;
    logic [31:0] a_seen = 32'd0, d_seen = 32'd0, rsp = 32'd0;
    @(negedge i_clk);
    chk("cmd_ready", 32'(o_cmd_ready), 1);
    i_cmd_valid = 1'b1; i_cmd_write = wr; i_cmd_addr = addr; i_cmd_data = data;
    i_start = with_start;
    @(posedge i_clk);
    #1;
    i_cmd_valid = 1'b0; i_start = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge i_clk);
      lat++;
      if (o_logic_en) en_seen++;
      if (o_reg_ctl != 2'd0) begin
        nctl++; ctl_seen = o_reg_ctl; a_seen = o_reg_addr; d_seen = o_reg_data;
      end
      if (o_rsp_valid) begin
        got = 1; rsp = o_rsp_data;
      end
    end
    chk("rsp_seen", 32'(got), 1);
    chk("rsp_latency", 32'(lat), 32'(exp_lat));
    chk("ctl_cycles", 32'(nctl), 1);
    chk("ctl_kind", 32'(ctl_seen), wr ? 32'd2 : 32'd1);
    chk("issue_addr", a_seen, addr);
    if (wr) chk("issue_data", d_seen, data);
    chk("rsp_data", rsp, exp_rsp);
    chk("cmd_no_logic_en", 32'(en_seen), 0);
    @(negedge i_clk);
    chk("rsp_pulse_end", 32'(o_rsp_valid), 0);
    chk("cmd_back_idle", 32'(o_busy), 0);
    $display("cmd %s addr=0x%08h data=0x%08h start=%0d -> rsp=0x%08h lat=%0d",
             wr ? "WR" : "RD", addr, data, with_start, rsp, lat);
  endtask

  task automatic do_run(input int h);
    int  cyc_e, polls_e, polls, t, last_t;
    bit  done_e, to_e, fin;
    run_model(h, cyc_e, done_e, to_e, polls_e);
    halt_after = h;
    @(negedge i_clk);
    chk("run_cmd_ready", 32'(o_cmd_ready), 1);
    i_start = 1'b1;
    en_count = 0;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    polls = 0; t = 0; last_t = 0; fin = 0;
    for (int c = 0; c < 400 && !fin; c++) begin
      @(negedge i_clk);
      t++;
      if (o_reg_ctl == 2'd1) begin
        chk("poll_addr", o_reg_addr, 0);
        polls++;
        if (polls > 1) chk("poll_period", 32'(t - last_t), 32'(PER));
        last_t = t;
      end
      if (!o_busy) fin = 1;
    end
    chk("run_ended", 32'(fin), 1);
    chk("run_done", 32'(o_done), 32'(done_e));
    chk("run_timeout", 32'(o_timeout), 32'(to_e));
    chk("run_cycles", o_cycles, 32'(cyc_e));
    chk("run_logic_en_off", 32'(o_logic_en), 0);
    chk("run_enabled_count", 32'(en_count), 32'(cyc_e));
    chk("run_polls", 32'(polls), 32'(polls_e));
    exp_done = done_e; exp_to = to_e; exp_cyc = cyc_e;
    $display("run halt_after=%0d -> done=%0d timeout=%0d cycles=%0d polls=%0d",
             h, o_done, o_timeout, o_cycles, polls);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rsp;
    int          exp_lat;
  } vec_t;

  vec_t vt [6];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          wr;
    logic [31:0] addr, data, expv;

    vt[0] = '{1'b1, 32'd4, 32'hDEADBEEF, 32'd0,         2};
    vt[1] = '{1'b0, 32'd4, 32'd0,        32'hDEADBEEF,  3};
    vt[2] = '{1'b1, 32'd9, 32'h12345678, 32'd0,         2};
    vt[3] = '{1'b0, 32'd9, 32'd0,        32'h12345678,  3};
    vt[4] = '{1'b0, 32'd0, 32'd0,        32'd1,         3};
    vt[5] = '{1'b0, 32'd5, 32'd0,        32'd0,         3};

    for (int k = 0; k < 16; k++) exp_mem[k] = 32'd0;
    i_rst = 1'b1; i_cmd_valid = 1'b0; i_cmd_write = 1'b0;
    i_cmd_addr = 32'd0; i_cmd_data = 32'd0; i_start = 1'b0;

    repeat (2) @(posedge i_clk);
    #1;
    check_reset(1'b0);
    @(negedge i_clk);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;
    chk("ready_after_reset", 32'(o_cmd_ready), 1);

    halt_after = 0;
    for (int v = 0; v < 6; v++) begin
      do_cmd(vt[v].wr, vt[v].addr, vt[v].data, 1'b0, vt[v].exp_rsp, vt[v].exp_lat);
      if (vt[v].wr) exp_mem[vt[v].addr[3:0]] = vt[v].data;
    end

    do_run(40);
    chk("halt_run_cycles_54", o_cycles, 32'd54);
    do_run(1000000);
    chk("timeout_run_cycles_100", o_cycles, 32'd100);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        do_run(int'($urandom_range(0, 120)));
      end else begin
        wr   = 1'($urandom_range(0, 1));
        addr = wr ? 32'($urandom_range(1, 15)) : 32'($urandom_range(0, 15));
        data = $urandom;
        if (wr)                expv = 32'd0;
        else if (addr == 32'd0) expv = (en_count >= halt_after) ? 32'd1 : 32'd0;
        else                   expv = exp_mem[addr[3:0]];
        do_cmd(wr, addr, data, 1'b0, expv, wr ? 2 : 3);
        if (wr) exp_mem[addr[3:0]] = data;
        chk("sticky_done", 32'(o_done), 32'(exp_done));
        chk("sticky_timeout", 32'(o_timeout), 32'(exp_to));
        chk("sticky_cycles", o_cycles, 32'(exp_cyc));
      end
    end

    // Reset in the middle of a run, then a colliding start and command.
    halt_after = 1000000;
    @(negedge i_clk);
    i_start = 1'b1;
    en_count = 0;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    repeat (30) @(negedge i_clk);
    chk("midrun_logic_en", 32'(o_logic_en), 1);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    check_reset(1'b0);
    @(negedge i_clk);
    i_rst = 1'b0;
    do_cmd(1'b0, 32'd4, 32'd0, 1'b1, exp_mem[4], 3);
    chk("collide_cycles", o_cycles, 0);
    chk("collide_done", 32'(o_done), 0);
    chk("collide_timeout", 32'(o_timeout), 0);
    chk("collide_logic_en", 32'(o_logic_en), 0);
    $display("reset mid-run, start+cmd collision -> busy=%0d cycles=%0d", o_busy, o_cycles);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
